seq_alu_display: RTL



---
 rtl/alu_pkg.sv | 27 ++
 rtl/seven_seg_decoder.sv | 16 +
 rtl/seq_alu_display.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and display constants for the sequential ALU and its
// seven-segment display decoders.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DIV = 2'b10,
    OP_REM = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    DONE = 2'b10
  } alu_state_t;

  // Active-low glyphs {g,f,e,d,c,b,a}; entry k is the glyph for hex digit k
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex-digit to active-low seven-segment glyph decoder.
module seven_seg_decoder
  import alu_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    for (int i = 0; i < 16; i++) begin
      if (digit == 4'(i)) segments = HEX_GLYPHS[i];
    end
  end

endmodule

// File: rtl/seq_alu_display.sv
// Clocked ALU with start/done handshake, multi-cycle restoring divider and
// seven-segment outputs for both operands and the result.
module seq_alu_display
  import alu_pkg::*;
#(
  parameter  int N      = 8,
  localparam int DIGITS = (N + 3) / 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      firstNum,
  input  logic [N-1:0]      secNum,
  input  logic [1:0]        operation,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      result,
  output logic              carry,
  output logic              negative,
  output logic              zero,
  output logic              overflow,
  output logic [7*DIGITS-1:0] firstSegments,
  output logic [7*DIGITS-1:0] secondSegments,
  output logic [7*DIGITS-1:0] resultSegments
);

  localparam int CW = $clog2(N);
  localparam int PW = 4 * DIGITS;

  alu_state_t state, next_state;
  alu_op_t    op_code;
  logic [N-1:0]  op_a, op_b;
  logic [N:0]    div_rem;
  logic [N-1:0]  div_quot;
  logic [CW-1:0] count;

  logic [N:0]   add_sum;
  logic [N-1:0] sub_diff;
  logic [N-1:0] div0_val;
  logic [N:0]   trial, trial_diff, step_rem;
  logic [N-1:0] step_quot, div_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state plus the arithmetic the datapath commits on each edge; the
  // divider shifts the dividend MSB into the remainder and keeps the trial
  // subtraction only when it does not borrow.
  always_comb begin
    next_state = state;
    add_sum    = {1'b0, firstNum} + {1'b0, secNum};
    sub_diff   = firstNum - secNum;
    div0_val   = (operation == OP_REM) ? firstNum : '1;
    trial      = (N+1)'({div_rem, div_quot[N-1]});
    trial_diff = trial - {1'b0, op_b};
    step_rem   = trial;
    step_quot  = {div_quot[N-2:0], 1'b0};
    if (!trial_diff[N]) begin
      step_rem  = trial_diff;
      step_quot = {div_quot[N-2:0], 1'b1};
    end
    div_val = (op_code == OP_REM) ? step_rem[N-1:0] : step_quot;

    case (state)
      IDLE:    if (start) next_state = (operation[1] && secNum != '0) ? DIV : DONE;
      DIV:     if (count == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Operands latch only on acceptance; result and flags change only when an
  // operation completes, so they hold through DIV and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= OP_ADD;
      div_rem  <= '0;
      div_quot <= '0;
      count    <= '0;
      result   <= '0;
      carry    <= 1'b0;
      negative <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a    <= firstNum;
            op_b    <= secNum;
            op_code <= alu_op_t'(operation);
            case (alu_op_t'(operation))
              OP_ADD: begin
                result   <= add_sum[N-1:0];
                carry    <= add_sum[N];
                negative <= 1'b0;
                overflow <= 1'b0;
                zero     <= (add_sum[N-1:0] == '0);
              end
              OP_SUB: begin
                result   <= sub_diff;
                carry    <= 1'b0;
                negative <= (firstNum < secNum);
                overflow <= 1'b0;
                zero     <= (sub_diff == '0);
              end
              default: begin
                if (secNum == '0) begin
                  result   <= div0_val;
                  carry    <= 1'b0;
                  negative <= 1'b0;
                  overflow <= 1'b1;
                  zero     <= (div0_val == '0);
                end else begin
                  div_rem  <= '0;
                  div_quot <= firstNum;
                  count    <= CW'(N - 1);
                end
              end
            endcase
          end
        end
        DIV: begin
          div_rem  <= step_rem;
          div_quot <= step_quot;
          count    <= count - CW'(1);
          if (count == '0) begin
            result   <= div_val;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
            zero     <= (div_val == '0);
          end
        end
        default: ;
      endcase
    end
  end

  logic [PW-1:0] a_pad, b_pad, r_pad;
  assign a_pad = PW'(op_a);
  assign b_pad = PW'(op_b);
  assign r_pad = PW'(result);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digits
    seven_seg_decoder u_first  (.digit(a_pad[4*k +: 4]), .segments(firstSegments[7*k +: 7]));
    seven_seg_decoder u_second (.digit(b_pad[4*k +: 4]), .segments(secondSegments[7*k +: 7]));
    seven_seg_decoder u_result (.digit(r_pad[4*k +: 4]), .segments(resultSegments[7*k +: 7]));
  end

endmodule
